reorder_buffer_dual: RTL

- Circular in-order completion buffer for the dual-issue out-of-order core.
- Hands out the 5-bit destination tags consumed by the rename table and the reservation stations.
- Captures results from the same four broadcast buses the reservation stations snoop (two ALU, two load).
- Retires up to two completed entries per cycle, in program order, to the architectural register file.

---
 rtl/reorder_buffer_dual_pkg.sv | 25 ++
 rtl/reorder_buffer_dual_if.sv | 64 ++++++
 rtl/reorder_buffer_dual_rob_wb_match.sv | 27 ++
 rtl/reorder_buffer_dual.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_dual_pkg.sv
// Shared constants and types for the dual-issue reorder buffer.
// The broadcast port enumeration order is also the writeback priority (lowest value wins).
package reorder_buffer_dual_pkg;
    localparam int ROB_SIZE  = 32;
    localparam int TAG_W     = $clog2(ROB_SIZE);
    localparam int DATA_W    = 32;
    localparam int AREG_W    = 5;
    localparam int CNT_W     = TAG_W + 1;
    localparam int NUM_BCAST = 4;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        BC_ALU1 = 2'd0,
        BC_ALU2 = 2'd1,
        BC_LD1  = 2'd2,
        BC_LD2  = 2'd3
    } bcast_port_e;

    localparam bcast_port_e BCAST_HIGHEST = BC_ALU1;
    localparam bcast_port_e BCAST_LOWEST  = BC_LD2;
endpackage

// File: rtl/reorder_buffer_dual_if.sv
// Front-end, broadcast and commit signals of the reorder buffer.
// The master side is the core pipeline; the slave side is the buffer itself.
interface reorder_buffer_dual_if;
    import reorder_buffer_dual_pkg::*;

    logic  stall;
    logic  flush;
    logic  alloc1;
    logic  alloc2;
    logic  regwrite1;
    logic  regwrite2;
    areg_t dest1;
    areg_t dest2;
    tag_t  alloc_tag1;
    tag_t  alloc_tag2;
    logic  full_ROB;
    logic  empty_ROB;

    logic  alu1_wr;
    logic  alu2_wr;
    logic  ld1_wr;
    logic  ld2_wr;
    tag_t  alu1_res_tag;
    tag_t  alu2_res_tag;
    tag_t  ld1_res_tag;
    tag_t  ld2_res_tag;
    data_t alu1_res;
    data_t alu2_res;
    data_t ld1_res;
    data_t ld2_res;

    logic  commit1;
    logic  commit2;
    logic  commit_wr1;
    logic  commit_wr2;
    areg_t commit_dest1;
    areg_t commit_dest2;
    tag_t  commit_tag1;
    tag_t  commit_tag2;
    data_t commit_val1;
    data_t commit_val2;

    modport master (
        output stall, flush, alloc1, alloc2, regwrite1, regwrite2, dest1, dest2,
        output alu1_wr, alu2_wr, ld1_wr, ld2_wr,
        output alu1_res_tag, alu2_res_tag, ld1_res_tag, ld2_res_tag,
        output alu1_res, alu2_res, ld1_res, ld2_res,
        input  alloc_tag1, alloc_tag2, full_ROB, empty_ROB,
        input  commit1, commit2, commit_wr1, commit_wr2,
        input  commit_dest1, commit_dest2, commit_tag1, commit_tag2,
        input  commit_val1, commit_val2
    );

    modport slave (
        input  stall, flush, alloc1, alloc2, regwrite1, regwrite2, dest1, dest2,
        input  alu1_wr, alu2_wr, ld1_wr, ld2_wr,
        input  alu1_res_tag, alu2_res_tag, ld1_res_tag, ld2_res_tag,
        input  alu1_res, alu2_res, ld1_res, ld2_res,
        output alloc_tag1, alloc_tag2, full_ROB, empty_ROB,
        output commit1, commit2, commit_wr1, commit_wr2,
        output commit_dest1, commit_dest2, commit_tag1, commit_tag2,
        output commit_val1, commit_val2
    );
endinterface

// File: rtl/reorder_buffer_dual_rob_wb_match.sv
// Per-entry broadcast tag comparator: flags a hit on any result bus and forwards
// the data of the highest-priority matching bus.
module rob_wb_match
    import reorder_buffer_dual_pkg::*;
#(
    parameter tag_t ENTRY_TAG = '0
) (
    input  logic [NUM_BCAST-1:0] i_wr,
    input  tag_t                 i_tag  [NUM_BCAST],
    input  data_t                i_data [NUM_BCAST],
    output logic                 o_hit,
    output data_t                o_data
);

    // Walk from lowest to highest priority so the strongest match is applied last.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int p = int'(BCAST_LOWEST); p >= int'(BCAST_HIGHEST); p--) begin
            if (i_wr[p] && (i_tag[p] == ENTRY_TAG)) begin
                o_hit  = 1'b1;
                o_data = i_data[p];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_dual.sv
// Circular in-order completion buffer: hands out tags, captures broadcast results
// and retires up to two completed entries per cycle in program order.
module reorder_buffer_dual
    import reorder_buffer_dual_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    reorder_buffer_dual_if.slave bus
);

    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_done;
    logic [ROB_SIZE-1:0] r_write;
    areg_t               r_dest [ROB_SIZE];
    data_t               r_val  [ROB_SIZE];
    tag_t                r_head;
    tag_t                r_tail;
    cnt_t                r_count;

    logic  r_commit1, r_commit2, r_commit_wr1, r_commit_wr2;
    areg_t r_commit_dest1, r_commit_dest2;
    tag_t  r_commit_tag1, r_commit_tag2;
    data_t r_commit_val1, r_commit_val2;

    logic                 w_full;
    logic                 w_alloc_en;
    logic                 w_alloc1;
    logic                 w_alloc2;
    logic                 w_commit1;
    logic                 w_commit2;
    tag_t                 w_tag1;
    tag_t                 w_tag2;
    tag_t                 w_head1;
    cnt_t                 w_count_next;
    logic [ROB_SIZE-1:0]  w_retire;
    logic [ROB_SIZE-1:0]  w_alloc_s1;
    logic [ROB_SIZE-1:0]  w_alloc_s2;
    logic [ROB_SIZE-1:0]  w_wb_hit;
    data_t                w_wb_data [ROB_SIZE];
    logic [NUM_BCAST-1:0] w_bc_wr;
    tag_t                 w_bc_tag  [NUM_BCAST];
    data_t                w_bc_data [NUM_BCAST];

    assign w_bc_wr[BC_ALU1]   = bus.alu1_wr;
    assign w_bc_wr[BC_ALU2]   = bus.alu2_wr;
    assign w_bc_wr[BC_LD1]    = bus.ld1_wr;
    assign w_bc_wr[BC_LD2]    = bus.ld2_wr;
    assign w_bc_tag[BC_ALU1]  = bus.alu1_res_tag;
    assign w_bc_tag[BC_ALU2]  = bus.alu2_res_tag;
    assign w_bc_tag[BC_LD1]   = bus.ld1_res_tag;
    assign w_bc_tag[BC_LD2]   = bus.ld2_res_tag;
    assign w_bc_data[BC_ALU1] = bus.alu1_res;
    assign w_bc_data[BC_ALU2] = bus.alu2_res;
    assign w_bc_data[BC_LD1]  = bus.ld1_res;
    assign w_bc_data[BC_LD2]  = bus.ld2_res;

    // Requests while full are dropped entirely, so a dual allocation never overruns head.
    assign w_full     = (r_count > cnt_t'(ROB_SIZE - 2));
    assign w_tag1     = r_tail;
    assign w_tag2     = bus.alloc1 ? r_tail + tag_t'(1) : r_tail;
    assign w_alloc_en = ~bus.stall & ~bus.flush & ~w_full;
    assign w_alloc1   = w_alloc_en & bus.alloc1;
    assign w_alloc2   = w_alloc_en & bus.alloc2;
    assign w_alloc_s1 = ROB_SIZE'(w_alloc1) << w_tag1;
    assign w_alloc_s2 = ROB_SIZE'(w_alloc2) << w_tag2;

    assign w_head1   = r_head + tag_t'(1);
    assign w_commit1 = r_busy[r_head] & r_done[r_head];
    assign w_commit2 = w_commit1 & r_busy[w_head1] & r_done[w_head1];
    assign w_retire  = (ROB_SIZE'(w_commit1) << r_head) | (ROB_SIZE'(w_commit2) << w_head1);

    assign w_count_next = r_count + cnt_t'(w_alloc1) + cnt_t'(w_alloc2)
                        - cnt_t'(w_commit1) - cnt_t'(w_commit2);

    for (genvar g = 0; g < ROB_SIZE; g++) begin : g_match
        rob_wb_match #(
            .ENTRY_TAG (tag_t'(g))
        ) u_match (
            .i_wr   (w_bc_wr),
            .i_tag  (w_bc_tag),
            .i_data (w_bc_data),
            .o_hit  (w_wb_hit[g]),
            .o_data (w_wb_data[g])
        );
    end

    // Retire, allocate and writeback target disjoint entries, so their order here is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_done  <= '0;
            r_write <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_dest[i] <= '0;
                r_val[i]  <= '0;
            end
        end else if (bus.flush) begin
            r_busy <= '0;
            r_done <= '0;
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (w_retire[i]) begin
                    r_busy[i] <= 1'b0;
                    r_done[i] <= 1'b0;
                end else if (w_alloc_s1[i] || w_alloc_s2[i]) begin
                    r_busy[i]  <= 1'b1;
                    r_done[i]  <= w_alloc_s1[i] ? ~bus.regwrite1 : ~bus.regwrite2;
                    r_write[i] <= w_alloc_s1[i] ? bus.regwrite1 : bus.regwrite2;
                    r_dest[i]  <= w_alloc_s1[i] ? bus.dest1 : bus.dest2;
                    r_val[i]   <= '0;
                end else if (w_wb_hit[i] && r_busy[i] && !r_done[i]) begin
                    r_done[i] <= 1'b1;
                    r_val[i]  <= w_wb_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + tag_t'(w_commit1) + tag_t'(w_commit2);
            r_tail  <= r_tail + tag_t'(w_alloc1) + tag_t'(w_alloc2);
            r_count <= w_count_next;
        end
    end

    // Commit fields are zeroed whenever their pulse is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.flush) begin
            r_commit1      <= 1'b0;
            r_commit2      <= 1'b0;
            r_commit_wr1   <= 1'b0;
            r_commit_wr2   <= 1'b0;
            r_commit_dest1 <= '0;
            r_commit_dest2 <= '0;
            r_commit_tag1  <= '0;
            r_commit_tag2  <= '0;
            r_commit_val1  <= '0;
            r_commit_val2  <= '0;
        end else begin
            r_commit1      <= w_commit1;
            r_commit2      <= w_commit2;
            r_commit_wr1   <= w_commit1 ? r_write[r_head] : 1'b0;
            r_commit_wr2   <= w_commit2 ? r_write[w_head1] : 1'b0;
            r_commit_dest1 <= w_commit1 ? r_dest[r_head] : '0;
            r_commit_dest2 <= w_commit2 ? r_dest[w_head1] : '0;
            r_commit_tag1  <= w_commit1 ? r_head : '0;
            r_commit_tag2  <= w_commit2 ? w_head1 : '0;
            r_commit_val1  <= w_commit1 ? r_val[r_head] : '0;
            r_commit_val2  <= w_commit2 ? r_val[w_head1] : '0;
        end
    end

    assign bus.alloc_tag1   = w_tag1;
    assign bus.alloc_tag2   = w_tag2;
    assign bus.full_ROB     = w_full;
    assign bus.empty_ROB    = (r_count == '0);
    assign bus.commit1      = r_commit1;
    assign bus.commit2      = r_commit2;
    assign bus.commit_wr1   = r_commit_wr1;
    assign bus.commit_wr2   = r_commit_wr2;
    assign bus.commit_dest1 = r_commit_dest1;
    assign bus.commit_dest2 = r_commit_dest2;
    assign bus.commit_tag1  = r_commit_tag1;
    assign bus.commit_tag2  = r_commit_tag2;
    assign bus.commit_val1  = r_commit_val1;
    assign bus.commit_val2  = r_commit_val2;

endmodule
